// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: on-chip instruction memory, credit-gated sequential fetch,
// small output FIFO with valid/ready handshake and branch redirect.
module instruction_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter int              IMEM_DEPTH = 256,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [XLEN-1:0]               imem_wdata,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [XLEN-1:0]               out_instr,
    output logic [XLEN-1:0]               out_pc,
    output logic                          fetch_err
);
    localparam int              AW      = $clog2(IMEM_DEPTH);
    localparam int              PW      = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]     DEPTH_C = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]     CNT_ONE = (PW+1)'(1);
    localparam logic [PW-1:0]   PTR_ONE = PW'(1);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] r_mem        [IMEM_DEPTH];
    logic [XLEN-1:0] r_fifo_instr [FIFO_DEPTH];
    logic [XLEN-1:0] r_fifo_pc    [FIFO_DEPTH];
    logic [PW-1:0]   r_wptr, r_rptr;
    logic [PW:0]     r_count;
    logic [XLEN-1:0] r_pc;
    logic            r_fetch_err;

    logic            w_issue, w_pop;
    logic [AW-1:0]   w_ridx;
    logic [XLEN-1:0] w_rdata;

    // A read completes at the edge that ends its issue cycle, so nothing is ever
    // in flight across an edge and the credit check reduces to the FIFO count.
    assign w_issue = (r_count < DEPTH_C);
    assign w_pop   = (r_count != '0) && out_ready;
    assign w_ridx  = r_pc[AW+1:2];
    assign w_rdata = r_mem[w_ridx];

    assign out_valid = (r_count != '0);
    assign out_instr = r_fifo_instr[r_rptr];
    assign out_pc    = r_fifo_pc[r_rptr];
    assign fetch_err = r_fetch_err;

    // Program load port; contents survive reset.
    always_ff @(posedge clk) begin
        if (imem_we)
            r_mem[imem_waddr] <= imem_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_fetch_err <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc[i]    <= '0;
            end
        end else begin
            r_fetch_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                r_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_issue) begin
                    r_fifo_instr[r_wptr] <= w_rdata;
                    r_fifo_pc[r_wptr]    <= r_pc;
                    r_wptr               <= r_wptr + PTR_ONE;
                    r_pc                 <= r_pc + PC_STEP;
                end
                if (w_pop)
                    r_rptr <= r_rptr + PTR_ONE;
                unique case ({w_issue, w_pop})
                    2'b10:   r_count <= r_count + CNT_ONE;
                    2'b01:   r_count <= r_count - CNT_ONE;
                    default: ;
                endcase
            end
        end
    end
endmodule
